// File: rtl/async_fifo_flop_read_control.sv
// Read-side control for the flop-based async FIFO.
// It brings the write gray pointer into the read clock domain and keeps the
// read binary and gray pointers. From these it drives the head address, the
// empty and almost-empty flags, and an occupancy level. The read gray pointer
// goes back to the write domain, where it is used to detect full.
// Optional feature: define ASYNC_FIFO_RD_UNDERFLOW_ERR_EN to add the sticky
// underflow_err output and an assertion against popping while empty.

module async_fifo_flop_read_control #(
  parameter int unsigned READ_COUNTER_BITS   = 4,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned ALMOST_EMPTY_THRESH = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         fifo_pop,
  input  logic [READ_COUNTER_BITS-1:0] write_gcode_ptr,
  output logic [READ_COUNTER_BITS-2:0] read_memory_addr,
  output logic [READ_COUNTER_BITS-1:0] read_gcode_ptr,
  output logic                         fifo_empty,
  output logic                         almost_empty,
  output logic [READ_COUNTER_BITS-1:0] fifo_level
`ifdef ASYNC_FIFO_RD_UNDERFLOW_ERR_EN
  ,
  output logic                         underflow_err
`endif
);

  localparam int unsigned PTR_W = READ_COUNTER_BITS;
  localparam int unsigned ADDR_W = READ_COUNTER_BITS - 1;
  localparam logic [PTR_W:0] AE_THRESH = (PTR_W + 1)'(ALMOST_EMPTY_THRESH);

  // Write-pointer synchronizer chain. Stage 0 samples the asynchronous input.
  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] wr_gptr_sync_c;
  logic [PTR_W-1:0] wr_bin_sync_c;

  // Read pointers
  logic [PTR_W-1:0] rd_bin_q;
  logic [PTR_W-1:0] rd_bin_d;
  logic [PTR_W-1:0] rd_gray_q;
  logic [PTR_W-1:0] rd_gray_d;
  logic             rd_en_c;

  // Plain flop chain for the gray vector; only the gray code crosses domains
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= write_gcode_ptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wr_gptr_sync_c = sync_q[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of gray bits N-1 down to i
  always_comb begin
    wr_bin_sync_c = '0;
    for (int unsigned i = 0; i < PTR_W; i++) begin
      wr_bin_sync_c[i] = ^(wr_gptr_sync_c >> i);
    end
  end

  // A pop while empty is dropped
  assign rd_en_c = fifo_pop & ~fifo_empty;

  // Next read pointers; the gray pointer is encoded from the next binary value
  always_comb begin
    rd_bin_d  = rd_bin_q;
    rd_gray_d = rd_gray_q;
    if (rd_en_c) begin
      rd_bin_d  = rd_bin_q + PTR_W'(1);
      rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
    end
  end

  // Read pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
    end
  end

  // Flags and level. These are decoded only from flops, so they do not glitch.
  // The level is pessimistic because the write pointer it uses is late.
  always_comb begin
    read_memory_addr = rd_bin_q[ADDR_W-1:0];
    read_gcode_ptr   = rd_gray_q;
    fifo_empty       = (rd_gray_q == wr_gptr_sync_c);
    fifo_level       = wr_bin_sync_c - rd_bin_q;
    almost_empty     = ({1'b0, fifo_level} <= AE_THRESH);
  end

`ifdef ASYNC_FIFO_RD_UNDERFLOW_ERR_EN
  logic underflow_q;

  // Sticky underflow flag; only reset clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q <= 1'b0;
    end else if (fifo_pop && fifo_empty) begin
      underflow_q <= 1'b1;
    end
  end

  assign underflow_err = underflow_q;

  // A pop must never be issued against an empty FIFO
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
                                    !(fifo_pop && fifo_empty));
`endif

endmodule

// File: tb/tb_async_fifo_flop_read_control.sv
// Directed bench for async_fifo_flop_read_control with the default parameters
// (4-bit pointers, 2 sync stages, almost-empty threshold 1).
module tb_async_fifo_flop_read_control;

  logic       clk;
  logic       reset_n;
  logic       fifo_pop;
  logic [3:0] write_gcode_ptr;
  logic [2:0] read_memory_addr;
  logic [3:0] read_gcode_ptr;
  logic       fifo_empty;
  logic       almost_empty;
  logic [3:0] fifo_level;
`ifdef ASYNC_FIFO_RD_UNDERFLOW_ERR_EN
  logic       underflow_err;
`endif

  int checks = 0;
  int errors = 0;

  async_fifo_flop_read_control dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fifo_pop         (fifo_pop),
    .write_gcode_ptr  (write_gcode_ptr),
    .read_memory_addr (read_memory_addr),
    .read_gcode_ptr   (read_gcode_ptr),
    .fifo_empty       (fifo_empty),
    .almost_empty     (almost_empty),
    .fifo_level       (fifo_level)
`ifdef ASYNC_FIFO_RD_UNDERFLOW_ERR_EN
    ,
    .underflow_err    (underflow_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] addr, input logic [3:0] gptr,
                             input logic empty, input logic ae, input logic [3:0] lvl);
    check({tag, ".addr"},  32'(read_memory_addr), 32'(addr));
    check({tag, ".gptr"},  32'(read_gcode_ptr),   32'(gptr));
    check({tag, ".empty"}, 32'(fifo_empty),       32'(empty));
    check({tag, ".ae"},    32'(almost_empty),     32'(ae));
    check({tag, ".level"}, 32'(fifo_level),       32'(lvl));
  endtask

  initial begin
    reset_n         = 1'b0;
    fifo_pop        = 1'b0;
    write_gcode_ptr = 4'b0000;
    step(3);
    check_state("reset", 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0);
    reset_n = 1'b1;
    step(1);

    // Fill latency: gray(1)
    write_gcode_ptr = 4'b0001;
    step(1);
    check("fill.empty_edge1", 32'(fifo_empty), 32'd1);
    step(1);
    check_state("fill1", 3'd0, 4'b0000, 1'b0, 1'b1, 4'd1);
    write_gcode_ptr = 4'b0010;              // gray(3)
    step(2);
    check_state("fill3", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd3);

    // Drain: write at gray(8), hold pop for 10 cycles
    write_gcode_ptr = 4'b1100;
    step(2);
    check("drain.level8", 32'(fifo_level), 32'd8);
    fifo_pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("drain.addr%0d", i), 32'(read_memory_addr), (i < 8) ? 32'(i) : 32'd0);
      step(1);
    end
    fifo_pop = 1'b0;
    check_state("drained", 3'd0, 4'b1100, 1'b1, 1'b1, 4'd0);

    // Wrap: write at bin 14 (gray 1001), pop 6 to read bin 14
    write_gcode_ptr = 4'b1001;
    step(2);
    check("wrap.level6", 32'(fifo_level), 32'd6);
    fifo_pop = 1'b1;
    step(6);
    fifo_pop = 1'b0;
    check_state("wrap.rd14", 3'd6, 4'b1001, 1'b1, 1'b1, 4'd0);
    write_gcode_ptr = 4'b0011;              // gray(2), next lap
    step(2);
    check_state("wrap.w2r14", 3'd6, 4'b1001, 1'b0, 1'b0, 4'd4);
    fifo_pop = 1'b1;
    step(1);
    check_state("wrap.rd15", 3'd7, 4'b1000, 1'b0, 1'b0, 4'd3);
    step(1);
    check_state("wrap.rd0", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd2);
    step(1);
    fifo_pop = 1'b0;
    check_state("sim.pre", 3'd1, 4'b0001, 1'b0, 1'b1, 4'd1);

    // Simultaneous: synced write advances on the same edge as the pop
    write_gcode_ptr = 4'b0010;              // gray(3)
    step(1);
    fifo_pop = 1'b1;
    step(1);
    fifo_pop = 1'b0;
    check_state("sim.post", 3'd2, 4'b0011, 1'b0, 1'b1, 4'd1);

    // Last-entry pop with pop held an extra cycle
    fifo_pop = 1'b1;
    step(1);
    check_state("last.pop", 3'd3, 4'b0010, 1'b1, 1'b1, 4'd0);
    step(1);
    fifo_pop = 1'b0;
    check_state("last.held", 3'd3, 4'b0010, 1'b1, 1'b1, 4'd0);

    // Mid-stream reset with rd_bin = 5
    write_gcode_ptr = 4'b0100;              // gray(7)
    step(2);
    fifo_pop = 1'b1;
    step(2);
    check_state("mid.rd5", 3'd5, 4'b0111, 1'b0, 1'b0, 4'd2);
    fifo_pop = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_state("mid.reset", 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0);
    write_gcode_ptr = 4'b0000;
    step(2);
    reset_n = 1'b1;
    step(1);
    check_state("post.reset", 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0);

`ifdef ASYNC_FIFO_RD_UNDERFLOW_ERR_EN
    check("uf.init", 32'(underflow_err), 32'd0);
    fifo_pop = 1'b1;
    step(1);
    fifo_pop = 1'b0;
    check("uf.set", 32'(underflow_err), 32'd1);
    check("uf.gptr", 32'(read_gcode_ptr), 32'd0);
    step(3);
    check("uf.sticky", 32'(underflow_err), 32'd1);
    reset_n = 1'b0;
    #1;
    check("uf.clear", 32'(underflow_err), 32'd0);
    reset_n = 1'b1;
    step(1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_flop_read_control.md
Name: async_fifo_flop_read_control

Overview:
Read-side control for the flop-based async FIFO. It is the mirror of the write control.
- Synchronizes the write-domain gray pointer into the read clock domain.
- Keeps the read binary and gray pointers.
- Drives the read memory address and produces fifo_empty, almost_empty and an occupancy level.
- Its read_gcode_ptr output is synchronized back into the write domain for full detection.

Parameters:
READ_COUNTER_BITS, 4, pointer width; the FIFO has 2^(READ_COUNTER_BITS-1) entries (8 by default).
SYNC_STAGES, 2, flop stages in the write-pointer synchronizer; legal values are 2 or more.
ALMOST_EMPTY_THRESH, 1, almost_empty asserts when occupancy <= this value; legal range 0..2^(READ_COUNTER_BITS-1).

Ports:
clk  input  1  read-domain clock
reset_n  input  1  asynchronous active-low reset
fifo_pop  input  1  pop the head entry; ignored while fifo_empty=1
write_gcode_ptr  input  READ_COUNTER_BITS  write-domain gray pointer; asynchronous to clk
read_memory_addr  output  READ_COUNTER_BITS-1  address of the current head entry
read_gcode_ptr  output  READ_COUNTER_BITS  registered read gray pointer, sent to the write domain
fifo_empty  output  1  FIFO empty
almost_empty  output  1  occupancy <= ALMOST_EMPTY_THRESH
fifo_level  output  READ_COUNTER_BITS  occupancy as seen from the read domain, 0..2^(READ_COUNTER_BITS-1)

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (reset_n).
  - While reset_n=0, all synchronizer flops, the read binary pointer and read_gcode_ptr clear to 0.
  - Resulting outputs: read_memory_addr=0, fifo_empty=1, almost_empty=1, fifo_level=0.
- Reset mid-operation: reset_n low clears all state immediately; no pop completes on the reset edge.
- Synchronizer:
  - write_gcode_ptr passes through SYNC_STAGES flops to give wr_gptr_sync.
  - Only the gray-coded vector crosses domains; no logic sits between the synchronizer stages.
- Pop enable: rd_en = fifo_pop & ~fifo_empty.
  - On a clk edge with rd_en=1: rd_bin <= rd_bin+1, wrapping modulo 2^READ_COUNTER_BITS.
  - On the same edge: read_gcode_ptr <= (rd_bin+1) ^ ((rd_bin+1)>>1).
  - Pop while empty: pointers hold and the pop is silently dropped, unless the optional feature below is compiled in.
- Outputs from pointers:
  - read_memory_addr = rd_bin[READ_COUNTER_BITS-2:0], taken directly from the register.
  - The memory read is combinational on this address, so head data is valid in the same cycle as fifo_empty=0.
- Empty flag: fifo_empty = (read_gcode_ptr == wr_gptr_sync), i.e. full-width equality of two registered values.
  - It is combinational only from flops, so it is glitch-free.
- Level:
  - wr_bin_sync = gray-to-binary(wr_gptr_sync), with bit i = XOR of bits N-1 down to i.
  - fifo_level = (wr_bin_sync - rd_bin) modulo 2^READ_COUNTER_BITS.
  - The value is pessimistic: it never exceeds the true occupancy.
- Almost-empty: almost_empty = (fifo_level <= ALMOST_EMPTY_THRESH).
- Latency:
  - A write_gcode_ptr change is reflected in fifo_empty and fifo_level SYNC_STAGES clk edges after it is sampled.
  - A pop updates the pointers and flags on the next edge; there is no extra latency.
- Wrap-around:
  - The extra MSB distinguishes a lap, so empty and full are never confused.
  - Pointer 15 wraps to 0 with read_gcode_ptr 4'b1000 -> 4'b0000.
- Simultaneous pop and write arrival:
  - Both apply in the same cycle; the level changes net 0.
  - fifo_empty is evaluated on the updated values after the edge.
- Last-entry pop: popping the final entry sets fifo_empty=1 on the next edge.
  - A fifo_pop held high in the following cycle is ignored.

Optional Feature:
Macro ASYNC_FIFO_RD_UNDERFLOW_ERR_EN.
- Defined:
  - Adds output port underflow_err (1 bit), reset value 0.
  - underflow_err is a sticky register, set on any clk edge with fifo_pop=1 and fifo_empty=1.
  - Cleared only by reset_n.
  - Adds an assertion (disabled during reset) that no pop occurs while empty.
- Not defined:
  - The port and logic are absent.
  - An underflow pop is silently ignored, as described in Behaviour.

Test Plan:
- Reset: reset_n=0 asserted mid-stream with rd_bin=5 -> read_memory_addr=0, read_gcode_ptr=0, fifo_empty=1, almost_empty=1, fifo_level=0 immediately, without waiting for a clk edge.
- Fill latency: write_gcode_ptr 0->1 (gray of 1) -> fifo_empty falls exactly 2 edges later, fifo_level=1, almost_empty=1; then step to gray(3)=4'b0010 -> fifo_level=3, almost_empty=0.
- Drain: with write ptr at gray(8)=4'b1100, hold fifo_pop for 10 cycles -> exactly 8 pops, read_memory_addr 0..7, fifo_empty=1 after the 8th pop, read_gcode_ptr=4'b1100, the extra 2 pops are ignored.
- Wrap: continue writes and pops past count 15 -> read_gcode_ptr 4'b1000 -> 4'b0000, read_memory_addr 7 -> 0, fifo_level stays correct (e.g. write bin 2, read bin 14 -> level 4).
- Simultaneous: level 1, pop coincides with the synced write ptr advancing by 1 -> fifo_level stays 1, fifo_empty stays 0.
- Underflow (ASYNC_FIFO_RD_UNDERFLOW_ERR_EN defined): pop while empty -> underflow_err=1 on the next edge and stays 1 until reset_n; pointers unchanged.
